// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: two-stage, multi-lane modular add/sub with a shared modulus and valid/ready flow control.
module mod_addsub_pipe #(
  parameter int DW    = 14,
  parameter int LANES = 2,
  parameter bit GUARD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      op,
  input  logic [LANES*DW-1:0]   in1,
  input  logic [LANES*DW-1:0]   in2,
  input  logic [DW-1:0]         p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out,
  output logic [LANES-1:0]      out_err
);
  logic                      r_v1, r_v2;
  logic [LANES*(DW+1)-1:0]   r_t;
  logic [LANES-1:0]          r_op1, r_err1;
  logic [DW-1:0]             r_p1;
  logic [LANES*(DW+1)-1:0]   w_t;
  logic [LANES-1:0]          w_err;
  logic [LANES*DW-1:0]       w_res;
  logic                      w_adv2;
  assign w_adv2    = !r_v2 || out_ready;
  assign in_ready  = !r_v1 || w_adv2;
  assign out_valid = r_v2;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] w_a, w_b, w_sum;
    logic [DW:0]   w_t1;
    assign w_a = in1[k*DW +: DW];
    assign w_b = in2[k*DW +: DW];
    assign w_t[k*(DW+1) +: DW+1] = op[k] ? {1'b0, w_a} + {1'b0, w_b} : {1'b0, w_a} - {1'b0, w_b};
    assign w_err[k] = GUARD && (w_a >= p || w_b >= p);
    assign w_t1  = r_t[k*(DW+1) +: DW+1];
    assign w_sum = w_t1[DW-1:0] + r_p1;
    // add: subtract p once if the sum reached p; sub: add p back on borrow
    assign w_res[k*DW +: DW] = r_op1[k] ? (w_t1 >= {1'b0, r_p1} ? w_t1[DW-1:0] - r_p1 : w_t1[DW-1:0])
                                        : (w_t1[DW] ? w_sum : w_t1[DW-1:0]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      out     <= '0;
      out_err <= '0;
    end else begin
      if (in_ready) r_v1 <= in_valid;
      if (in_ready && in_valid) begin
        r_t    <= w_t;
        r_op1  <= op;
        r_p1   <= p;
        r_err1 <= w_err;
      end
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv2 && r_v1) begin
        out     <= w_res;
        out_err <= r_err1;
      end
    end
  end
endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb_mod_addsub_pipe: directed vectors plus a scoreboarded random stream for mod_addsub_pipe.
module tb_mod_addsub_pipe;
  localparam logic [13:0] P = 14'd12289;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [1:0]  op = '0, out_err;
  logic [27:0] in1 = '0, in2 = '0, out;
  logic [13:0] p = P;
  int          n_chk = 0, n_err = 0;
  logic        mon_en = 1'b0, done = 1'b0, stalled = 1'b0;
  logic [29:0] held = '0;
  logic [29:0] q[$];

  always #5 clk = ~clk;

  mod_addsub_pipe #(.DW(14), .LANES(2), .GUARD(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .in1(in1), .in2(in2), .p(p), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [1:0] o, input logic [13:0] pp,
                      input logic [13:0] a1, a0, b1, b0, r1, r0, input logic [1:0] e);
    @(posedge clk); #1;
    op = o; p = pp; in1 = {a1, a0}; in2 = {b1, b0}; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".lat"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, ".v"}, out_valid, 1'b1);
    chk({tag, ".out"}, out, {r1, r0});
    chk({tag, ".err"}, out_err, e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (stalled) chk("stall.hold", {out_valid, out_err, out}, {1'b1, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stream.extra", out_valid, 1'b0);
        else chk("stream", {out_err, out}, q.pop_front());
      end
      stalled = out_valid && !out_ready;
      held    = {out_err, out};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ov", out_valid, 1'b0);
    chk("rst.out", out, 28'd0);
    chk("rst.err", out_err, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.rdy", in_ready, 1'b1);

    beat("v034", 2'b11, P, 14'd5, 14'd12288, 14'd7, 14'd12288, 14'd12, 14'd12287, 2'b00);
    beat("v035", 2'b00, P, 14'd100, 14'd0, 14'd100, 14'd12288, 14'd0, 14'd1, 2'b00);
    beat("v038", 2'b11, P, 14'd12289, 14'd3, 14'd0, 14'd4, 14'd0, 14'd7, 2'b10);
    beat("bnd", 2'b01, P, 14'd9, 14'd12288, 14'd9, 14'd1, 14'd0, 14'd0, 2'b00);
    beat("mix", 2'b10, P, 14'd12000, 14'd3, 14'd1000, 14'd10, 14'd711, 14'd12282, 2'b00);
    beat("p13", 2'b01, 14'd13, 14'd0, 14'd12, 14'd12, 14'd12, 14'd1, 14'd11, 2'b00);
    beat("err0", 2'b00, 14'd13, 14'd3, 14'd13, 14'd4, 14'd5, 14'd12, 14'd8, 2'b01);

    // fill with downstream stalled, then release with input still flowing
    @(posedge clk); #1;
    out_ready = 1'b0; op = 2'b11; p = P; in1 = {14'd1, 14'd2}; in2 = {14'd3, 14'd4}; in_valid = 1'b1;
    @(negedge clk);
    chk("fill.rdy0", in_ready, 1'b1);
    @(posedge clk); #1;
    in1 = {14'd5, 14'd6};
    @(negedge clk);
    chk("fill.rdy1", in_ready, 1'b1);
    @(posedge clk); #1;
    in1 = {14'd7, 14'd8};
    @(negedge clk);
    chk("fill.rdy2", in_ready, 1'b0);
    chk("fill.ov", out_valid, 1'b1);
    chk("fill.out", out, {14'd4, 14'd6});
    @(posedge clk);
    @(negedge clk);
    chk("stall.out", out, {14'd4, 14'd6});
    chk("stall.rdy", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("flow.rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in1 = {14'd9, 14'd10};
    @(negedge clk);
    chk("flow.out2", out, {14'd8, 14'd10});
    chk("flow.rdy2", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flow.out3", out, {14'd10, 14'd12});
    @(negedge clk);
    chk("flow.out4", out, {14'd12, 14'd14});
    @(negedge clk);
    chk("flow.empty", out_valid, 1'b0);

    // random stream against a modular-arithmetic model
    mon_en = 1'b1;
    fork
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
          int pp, a0, b0, a1, b1, r0, r1, w;
          logic [1:0] o;
          pp = $urandom_range(16383, 2);
          a0 = $urandom_range(pp - 1, 0); b0 = $urandom_range(pp - 1, 0);
          a1 = $urandom_range(pp - 1, 0); b1 = $urandom_range(pp - 1, 0);
          o  = 2'($urandom_range(3, 0));
          r0 = o[0] ? (a0 + b0) % pp : (a0 + pp - b0) % pp;
          r1 = o[1] ? (a1 + b1) % pp : (a1 + pp - b1) % pp;
          op = o; p = pp[13:0]; in1 = {a1[13:0], a0[13:0]}; in2 = {b1[13:0], b0[13:0]}; in_valid = 1'b1;
          @(negedge clk);
          w = 0;
          while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
          end
          if (!in_ready) chk("stream.rdy_timeout", in_ready, 1'b1);
          q.push_back({2'b00, r1[13:0], r0[13:0]});
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(1, 0));
        end
      end
    join
    out_ready = 1'b1;
    for (int w = 0; w < 20 && q.size() != 0; w++) @(negedge clk);
    @(negedge clk);
    chk("stream.drain", q.size(), 0);
    mon_en = 1'b0;

    // reset with two beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0; op = 2'b11; p = P; in1 = {14'd12289, 14'd1}; in2 = {14'd0, 14'd1}; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst.ov", out_valid, 1'b0);
    chk("mrst.out", out, 28'd0);
    chk("mrst.err", out_err, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.rdy", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mrst.stale", out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mod_addsub_pipe.md
MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

Interface
REQ-001 Parameter DW, default 14: operand and modulus width in bits; legal range 4..64.
REQ-002 Parameter LANES, default 2: number of independent modular lanes sharing one modulus and one handshake.
REQ-003 Parameter GUARD, default 1: when 1 a range check is built; when 0 out_err is tied to 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  upstream presents a beat.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 op  input  LANES  per-lane mode; bit k: 0 = (a-b) mod p, 1 = (a+b) mod p.
REQ-009 in1  input  LANES*DW  lane k operand a at bits [k*DW +: DW].
REQ-010 in2  input  LANES*DW  lane k operand b, same packing.
REQ-011 p  input  DW  modulus, sampled with each accepted beat; p >= 2.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out  output  LANES*DW  lane k result, same packing.
REQ-015 out_err  output  LANES  lane k had a >= p or b >= p on its input beat.

Function
REQ-016 A beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
REQ-017 Pipeline: two register stages (S1 raw op, S2 correction), each holding a valid bit, LANES lanes, p and op.
REQ-018 S1 computes per lane: add -> t = a+b in DW+1 bits; sub -> t = {0,a}-{0,b} in DW+1 bits; S1 also registers p, op, and the range flag.
REQ-019 S2 per lane: add -> u = t-p in DW+2 signed bits; result = u >= 0 ? u[DW-1:0] : t[DW-1:0].
REQ-020 S2 per lane: sub -> result = t[DW] ? (t+{0,p})[DW-1:0] : t[DW-1:0].
REQ-021 Results for in-range inputs (a,b < p) SHALL equal the true modular result in [0,p-1]; out-of-range inputs use the same formulas without saturation and set out_err[k].
REQ-022 Latency: an accepted beat appears on out two cycles after acceptance when out_ready stays high.
REQ-023 Throughput: one beat per cycle with out_ready held high.
REQ-024 A stage advances when its successor is empty or being drained the same cycle; in_ready = !S1.valid || S2 advances this cycle (S2 advances when !S2.valid || out_ready).
REQ-025 While out_valid && !out_ready, out, out_err and out_valid SHALL hold stable.
REQ-026 No beat is dropped, duplicated or reordered under any out_ready pattern; at most 2 beats in flight.
REQ-027 Acceptance and consumption in the same cycle with both stages full SHALL both occur (no bubble).
REQ-028 in_ready SHALL NOT depend combinationally on in_valid.
REQ-029 Lanes are independent; op and out_err bits for one lane never affect another.
REQ-030 Boundary: add a=b=p-1 -> p-2; sub a=0,b=p-1 -> 1; a=b -> 0 in either mode.

Reset
REQ-031 While rst is high at a clock edge: both valid bits clear, out = 0, out_err = 0, out_valid = 0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-033 Reset mid-operation discards all in-flight beats; none appear afterwards.

Verification (DW=14, LANES=2, p=12289)
REQ-034 op=2'b11, lane0 a=12288,b=12288, lane1 a=5,b=7, out_ready=1 -> two cycles later out lane0=12287, lane1=12, out_err=0.
REQ-035 op=2'b00, lane0 a=0,b=12288, lane1 a=100,b=100 -> lane0=1, lane1=0, out_err=0.
REQ-036 Stream 100 random beats, out_ready random 50% -> output sequence equals reference model in order, no loss or duplication, out stable while stalled.
REQ-037 Fill pipeline with out_ready=0 -> in_ready falls after 2 accepted beats; out_ready=1 with in_valid=1 -> accept and consume same cycle every cycle.
REQ-038 lane1 a=12289 (op add, b=0) -> out_err=2'b10, lane1 result=0.
REQ-039 Assert rst with 2 beats in flight -> next cycle out_valid=0, out=0; after release in_ready=1 and no stale beat appears.
